// File: rtl/perceptron.sv
// Single neuron: AXI4-Lite loads a weight BRAM, then an AXI-Stream of x-samples
// is multiply-accumulated against the weights (bias added per term).
module perceptron #(
    parameter int N_INPUTS = 5,
    parameter int ADDR_W   = 10
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [11:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [11:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        start,
    input  logic [31:0] x_tdata,
    input  logic        x_tvalid,
    output logic        x_tready,
    input  logic [31:0] bias,
    input  logic        biasValid,
    output logic [31:0] a_tdata,
    output logic        done,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   beat_cnt;
    logic [31:0]       wout, x_tdata_del, bias_reg, mul;
    logic [63:0]       sum, sum_nxt;
    logic              acc_en, beat, wr_en, rd_en;
    logic              unused_ok;

    // All handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a source holds valid and its payload stable until then.
    assign beat    = x_tvalid && (state == RUN);
    assign wr_en   = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
    assign rd_en   = s_axi_arvalid && s_axi_arready;
    assign mul     = wout * x_tdata_del;
    assign sum_nxt = acc_en ? sum + {32'd0, mul} + {32'd0, bias_reg} : sum;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign fsm_state   = state;
    assign unused_ok   = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], sum[63:32]};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_tready  = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                x_tready = 1'b1;
                if (x_tvalid && beat_cnt == LAST_BEAT) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight BRAM: port A is the AXI side, port B feeds the compute pipeline.
    always_ff @(posedge s_axi_aclk) begin
        wout <= mem[r_addr];
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (s_axi_wstrb[b])
                    mem[s_axi_awaddr[ADDR_W+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'd0;
        end else begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            if (!s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid) begin
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
            if (wr_en)                            s_axi_bvalid <= 1'b1;
            else if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            if (!s_axi_arready && s_axi_arvalid && !s_axi_rvalid)
                s_axi_arready <= 1'b1;
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= mem[s_axi_araddr[ADDR_W+1:2]];
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Weight and sample of a beat are registered on the same edge, so the
    // product term is always added exactly one cycle after its beat.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_addr      <= '0;
            beat_cnt    <= '0;
            x_tdata_del <= 32'd0;
            bias_reg    <= 32'd0;
            sum         <= 64'd0;
            acc_en      <= 1'b0;
            a_tdata     <= 32'd0;
            done        <= 1'b0;
        end else begin
            done   <= 1'b0;
            acc_en <= beat;
            if (biasValid) bias_reg <= bias;
            if (state == IDLE && start) begin
                r_addr   <= '0;
                beat_cnt <= '0;
                sum      <= 64'd0;
            end else begin
                sum <= sum_nxt;
                if (beat) begin
                    r_addr      <= r_addr + 1'b1;
                    beat_cnt    <= beat_cnt + 1'b1;
                    x_tdata_del <= x_tdata;
                end
            end
            if (state == DRAIN) begin
                a_tdata <= sum_nxt[31:0];
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_perceptron.sv
// Directed and randomized checks of the perceptron against a dot-product
// reference model held in the bench.
module tb_perceptron;

    localparam int N = 5;
    typedef logic [31:0] vec_t [N];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        start = 1'b0, x_tvalid = 1'b0, biasValid = 1'b0;
    logic [31:0] x_tdata = '0, bias = '0;
    logic        x_tready, done;
    logic [31:0] a_tdata;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    int done_pulses = 0;
    logic [31:0] wmem [0:1023];
    logic [31:0] bias_model = 32'd0;

    perceptron #(.N_INPUTS(N), .ADDR_W(10)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .start(start), .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .bias(bias), .biasValid(biasValid), .a_tdata(a_tdata), .done(done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (x_tvalid && x_tready) beats_seen++;
        if (done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input vec_t xs, input logic [31:0] b);
        logic [63:0] acc, p;
        acc = 64'd0;
        for (int i = 0; i < N; i++) begin
            p   = {32'd0, wmem[i]} * {32'd0, xs[i]};
            acc = acc + (p & 64'h0000_0000_FFFF_FFFF) + {32'd0, b};
        end
        return acc[31:0];
    endfunction

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit ok;
        @(posedge clk); #1;
        awaddr = addr; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        check("aw_w_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; break; end
        end
        check("bvalid", 32'(ok), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        for (int b = 0; b < 4; b++)
            if (strb[b]) wmem[addr[11:2]][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic axi_read_check(input string tag, input logic [11:0] addr);
        bit ok;
        @(posedge clk); #1;
        araddr = addr; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        check({tag, "_arready"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_rvalid"}, 32'(ok), 32'd1);
        check({tag, "_rdata"}, rdata, wmem[addr[11:2]]);
        check({tag, "_rresp"}, 32'(rresp), 32'd0);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic set_bias(input logic [31:0] b);
        @(posedge clk); #1;
        bias = b; biasValid = 1'b1;
        @(posedge clk); #1;
        biasValid = 1'b0; bias = $urandom;
        bias_model = b;
    endtask

    // gap_mode: 0 back-to-back, 1 valid toggling every cycle, 2 random gaps
    task automatic run_inf(input string tag, input vec_t xs, input int gap_mode,
                           input bit hold, output logic [31:0] res);
        int  idx;
        bit  phase, got;
        idx = 0; phase = 1'b1; got = 1'b0; res = 32'd0;
        beats_seen = 0; done_pulses = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c < 200 && idx < N; c++) begin
            x_tdata = xs[idx];
            case (gap_mode)
                0:       x_tvalid = 1'b1;
                1:       begin x_tvalid = phase; phase = !phase; end
                default: x_tvalid = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (x_tvalid && x_tready) idx++;
            @(posedge clk); #1;
        end
        x_tvalid = hold;
        x_tdata  = 32'hDEAD_BEEF;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; res = a_tdata; break; end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, a_tdata, res);
        check({tag, "_beats"}, 32'(beats_seen), 32'(N));
        check({tag, "_pulses"}, 32'(done_pulses), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; x_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        xs;
        logic [31:0] res;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_x_tready", 32'(x_tready), 32'd0);
        check("rst_a_tdata", a_tdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state_idle", 32'(fsm_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) axi_write(12'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < N; i++) axi_read_check("readback", 12'(4 * i));

        set_bias(32'd1);
        for (int i = 0; i < N; i++) xs[i] = 32'(i + 1);
        run_inf("basic", xs, 0, 1'b0, res);
        check("basic_result", res, ref_result(xs, bias_model));
        check("basic_result_60", res, 32'd60);

        run_inf("hold", xs, 0, 1'b1, res);
        check("hold_result", res, 32'd60);

        run_inf("toggle", xs, 1, 1'b0, res);
        check("toggle_result", res, 32'd60);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++)
                axi_write(12'(4 * i), $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
            set_bias($urandom);
            for (int i = 0; i < N; i++) xs[i] = $urandom;
            run_inf("random", xs, 2, 1'($urandom_range(0, 1)), res);
            check("random_result", res, ref_result(xs, bias_model));
        end

        axi_write(12'h000, 32'd1, 4'hF);
        axi_write(12'h000, 32'hFFFF_FFFF, 4'b0001);
        axi_read_check("strobe", 12'h000);
        check("strobe_model", wmem[0], 32'h0000_00FF);

        @(posedge clk); #1;
        start = 1'b1; x_tvalid = 1'b1; x_tdata = 32'd7;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_x_tready", 32'(x_tready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_a_tdata", a_tdata, 32'd0);
        check("abort_state_idle", 32'(fsm_state), 32'd0);
        start = 1'b0; x_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bias_model = 32'd0;
        for (int i = 0; i < N; i++) axi_read_check("post_reset", 12'(4 * i));

        for (int i = 0; i < N; i++) xs[i] = 32'($urandom_range(0, 1000));
        run_inf("post_reset_inf", xs, 2, 1'b0, res);
        check("post_reset_result", res, ref_result(xs, bias_model));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
